// File: rtl/mm_pkg.sv
// Shared types and constants for the Mastermind code judge.
// Holds the FSM state encoding, default geometry and the score-width helper.
package mm_pkg;

    localparam int MM_DIGITS      = 4;
    localparam int MM_DIGIT_W     = 4;
    localparam int MM_MAX_GUESSES = 8;

    typedef enum logic [2:0] {
        MM_IDLE       = 3'd0,
        MM_WAIT_CODE  = 3'd1,
        MM_WAIT_GUESS = 3'd2,
        MM_SCORE      = 3'd3,
        MM_DONE       = 3'd4
    } mm_judge_state_t;

    // Width needed to hold a count in 0..digits.
    function automatic int score_w(input int digits);
        return $clog2(digits + 1);
    endfunction

endpackage

// File: rtl/mm_code_judge_if.sv
// Player-facing bus of the code judge: round control, enters, switch bus and score outputs.
// master drives the player side, slave is the judge.
interface mm_code_judge_if
    import mm_pkg::*;
#(
    parameter int DIGITS      = MM_DIGITS,
    parameter int DIGIT_W     = MM_DIGIT_W,
    parameter int MAX_GUESSES = MM_MAX_GUESSES
) ();

    localparam int SW = score_w(DIGITS);
    localparam int GW = $clog2(MAX_GUESSES + 1);

    logic                        take_code;
    logic                        active_p;
    logic                        enterA;
    logic                        enterB;
    logic [DIGITS*DIGIT_W-1:0]   code_in;

    logic                        code_loaded;
    logic                        result_valid;
    logic [SW-1:0]               exact_cnt;
    logic [SW-1:0]               partial_cnt;
    logic [GW-1:0]               guesses_left;
    logic                        game_over;
    logic                        winner_p;
    logic                        code_err;

    modport master (
        output take_code, active_p, enterA, enterB, code_in,
        input  code_loaded, result_valid, exact_cnt, partial_cnt,
               guesses_left, game_over, winner_p, code_err
    );

    modport slave (
        input  take_code, active_p, enterA, enterB, code_in,
        output code_loaded, result_valid, exact_cnt, partial_cnt,
               guesses_left, game_over, winner_p, code_err
    );

endinterface

// File: rtl/mm_scorer.sv
// Combinational Mastermind scorer: exact hits and colour-only (partial) hits.
// Partial = sum over symbols of min(secret count, guess count) minus exact.
module mm_scorer
    import mm_pkg::*;
#(
    parameter int DIGITS  = MM_DIGITS,
    parameter int DIGIT_W = MM_DIGIT_W
) (
    input  logic [DIGITS*DIGIT_W-1:0] secret,
    input  logic [DIGITS*DIGIT_W-1:0] guess,
    output logic [score_w(DIGITS)-1:0] exact,
    output logic [score_w(DIGITS)-1:0] partial
);

    localparam int SW   = score_w(DIGITS);
    localparam int NSYM = 1 << DIGIT_W;

    logic [SW-1:0] exact_s;
    logic [SW-1:0] total_s;
    logic [SW-1:0] cnt_sec_s;
    logic [SW-1:0] cnt_gue_s;

    // Count positional matches, then per-symbol overlap of the two multisets.
    always_comb begin
        exact_s   = '0;
        total_s   = '0;
        cnt_sec_s = '0;
        cnt_gue_s = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (secret[i*DIGIT_W +: DIGIT_W] == guess[i*DIGIT_W +: DIGIT_W]) begin
                exact_s = exact_s + SW'(1'b1);
            end else begin
                exact_s = exact_s;
            end
        end
        for (int v = 0; v < NSYM; v++) begin
            cnt_sec_s = '0;
            cnt_gue_s = '0;
            for (int i = 0; i < DIGITS; i++) begin
                if (secret[i*DIGIT_W +: DIGIT_W] == DIGIT_W'(v)) begin
                    cnt_sec_s = cnt_sec_s + SW'(1'b1);
                end else begin
                    cnt_sec_s = cnt_sec_s;
                end
                if (guess[i*DIGIT_W +: DIGIT_W] == DIGIT_W'(v)) begin
                    cnt_gue_s = cnt_gue_s + SW'(1'b1);
                end else begin
                    cnt_gue_s = cnt_gue_s;
                end
            end
            total_s = total_s + ((cnt_sec_s < cnt_gue_s) ? cnt_sec_s : cnt_gue_s);
        end
    end

    assign exact   = exact_s;
    assign partial = total_s - exact_s;

endmodule

// File: rtl/mm_code_judge.sv
// Mastermind round judge: captures the setter's code, scores guesses, declares the winner.
// Optional MM_NO_REPEAT_EN rejects setter codes containing a repeated digit.
module mm_code_judge
    import mm_pkg::*;
#(
    parameter int DIGITS      = MM_DIGITS,
    parameter int DIGIT_W     = MM_DIGIT_W,
    parameter int MAX_GUESSES = MM_MAX_GUESSES
) (
    input  logic clk,
    input  logic reset,
    mm_code_judge_if.slave bus
);

    localparam int SW = score_w(DIGITS);
    localparam int GW = $clog2(MAX_GUESSES + 1);
    localparam int CW = DIGITS * DIGIT_W;

    localparam logic [2:0] ST_IDLE       = MM_IDLE;
    localparam logic [2:0] ST_WAIT_CODE  = MM_WAIT_CODE;
    localparam logic [2:0] ST_WAIT_GUESS = MM_WAIT_GUESS;
    localparam logic [2:0] ST_SCORE      = MM_SCORE;
    localparam logic [2:0] ST_DONE       = MM_DONE;

    logic [2:0]    state_r;
    logic [CW-1:0] secret_r;
    logic [CW-1:0] guess_r;
    logic          code_loaded_r;
    logic          result_valid_r;
    logic [SW-1:0] exact_r;
    logic [SW-1:0] partial_r;
    logic [GW-1:0] guesses_left_r;
    logic          game_over_r;
    logic          winner_r;
    logic          code_err_r;

    logic          setter_enter_s;
    logic          guesser_enter_s;
    logic          code_ok_s;
    logic [SW-1:0] exact_s;
    logic [SW-1:0] partial_s;
    logic [GW-1:0] gl_dec_s;

    assign setter_enter_s  = bus.active_p ? bus.enterA : bus.enterB;
    assign guesser_enter_s = bus.active_p ? bus.enterB : bus.enterA;
    assign gl_dec_s        = (guesses_left_r == '0) ? '0 : (guesses_left_r - GW'(1'b1));

    mm_scorer #(
        .DIGITS  (DIGITS),
        .DIGIT_W (DIGIT_W)
    ) u_scorer (
        .secret  (secret_r),
        .guess   (guess_r),
        .exact   (exact_s),
        .partial (partial_s)
    );

`ifdef MM_NO_REPEAT_EN
    // True when any two positions of the code hold the same symbol.
    function automatic logic has_repeat(input logic [CW-1:0] code);
        logic rep;
        rep = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            for (int j = i + 1; j < DIGITS; j++) begin
                if (code[i*DIGIT_W +: DIGIT_W] == code[j*DIGIT_W +: DIGIT_W]) begin
                    rep = 1'b1;
                end else begin
                    rep = rep;
                end
            end
        end
        return rep;
    endfunction

    assign code_ok_s = ~has_repeat(bus.code_in);
`else
    assign code_ok_s = 1'b1;
`endif

    // Round FSM; dropping take_code abandons the round ahead of any enter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r        <= ST_IDLE;
            secret_r       <= '0;
            guess_r        <= '0;
            code_loaded_r  <= 1'b0;
            result_valid_r <= 1'b0;
            exact_r        <= '0;
            partial_r      <= '0;
            guesses_left_r <= '0;
            game_over_r    <= 1'b0;
            winner_r       <= 1'b0;
            code_err_r     <= 1'b0;
        end else if (!bus.take_code) begin
            state_r        <= ST_IDLE;
            secret_r       <= '0;
            guess_r        <= '0;
            code_loaded_r  <= 1'b0;
            result_valid_r <= 1'b0;
            exact_r        <= '0;
            partial_r      <= '0;
            guesses_left_r <= '0;
            game_over_r    <= 1'b0;
            winner_r       <= 1'b0;
            code_err_r     <= 1'b0;
        end else begin
            result_valid_r <= 1'b0;
            code_err_r     <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    state_r <= ST_WAIT_CODE;
                end
                ST_WAIT_CODE: begin
                    if (setter_enter_s && code_ok_s) begin
                        secret_r       <= bus.code_in;
                        code_loaded_r  <= 1'b1;
                        guesses_left_r <= GW'(MAX_GUESSES);
                        state_r        <= ST_WAIT_GUESS;
                    end else if (setter_enter_s) begin
                        code_err_r <= 1'b1;
                    end else begin
                        state_r <= ST_WAIT_CODE;
                    end
                end
                ST_WAIT_GUESS: begin
                    // result_valid rises with SCORE; the counts follow when SCORE ends.
                    if (guesser_enter_s) begin
                        guess_r        <= bus.code_in;
                        result_valid_r <= 1'b1;
                        state_r        <= ST_SCORE;
                    end else begin
                        state_r <= ST_WAIT_GUESS;
                    end
                end
                ST_SCORE: begin
                    exact_r        <= exact_s;
                    partial_r      <= partial_s;
                    guesses_left_r <= gl_dec_s;
                    if (exact_s == SW'(DIGITS)) begin
                        state_r     <= ST_DONE;
                        game_over_r <= 1'b1;
                        winner_r    <= ~bus.active_p;
                    end else if (gl_dec_s == '0) begin
                        state_r     <= ST_DONE;
                        game_over_r <= 1'b1;
                        winner_r    <= bus.active_p;
                    end else begin
                        state_r <= ST_WAIT_GUESS;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_DONE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.code_loaded  = code_loaded_r;
    assign bus.result_valid = result_valid_r;
    assign bus.exact_cnt    = exact_r;
    assign bus.partial_cnt  = partial_r;
    assign bus.guesses_left = guesses_left_r;
    assign bus.game_over    = game_over_r;
    assign bus.winner_p     = winner_r;
    assign bus.code_err     = code_err_r;

endmodule
